// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
//
// Bundles every handshake and bus signal of alu_issue_ctrl:
//   request side  : req_valid/req_ready, opcode, funct3, funct7, rs1_data,
//                   rs2_data, imm
//   ALU side      : alu_control, alu_inp1, alu_inp2 (to ALU),
//                   alu_result, alu_zeroflag (from ALU)
//   response side : rsp_valid/rsp_ready, rsp_result, rsp_branch_taken,
//                   rsp_illegal
//   status        : op_count
//
// The master modport is the controller's view. The slave modport is the view
// of its surroundings: decode stage, ALU and response consumer.
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;

    logic [3:0]  alu_control;
    logic [31:0] alu_inp1;
    logic [31:0] alu_inp2;
    logic [31:0] alu_result;
    logic        alu_zeroflag;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_branch_taken;
    logic        rsp_illegal;

    logic [31:0] op_count;

    modport master (
        input  req_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm,
        input  alu_result, alu_zeroflag,
        input  rsp_ready,
        output req_ready,
        output alu_control, alu_inp1, alu_inp2,
        output rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal,
        output op_count
    );

    modport slave (
        output req_valid, opcode, funct3, funct7, rs1_data, rs2_data, imm,
        output alu_result, alu_zeroflag,
        output rsp_ready,
        input  req_ready,
        input  alu_control, alu_inp1, alu_inp2,
        input  rsp_valid, rsp_result, rsp_branch_taken, rsp_illegal,
        input  op_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Multi-cycle issue controller in front of the execute-stage ALU. It accepts
// one decoded instruction per request handshake, decodes the 4-bit ALU
// operation, registers the operands onto the ALU inputs, and captures the
// ALU result and zero flag one cycle later. The response carries the result,
// the branch decision and an illegal-encoding flag.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    alu_issue_ctrl_if.master: request handshake + fields, ALU
//          operands/op out and result/zero flag in, response handshake +
//          fields, completed-response counter op_count
//
// Sequencing: IDLE -> EXEC -> RESP for legal ops (3 cycles minimum),
//             IDLE -> RESP for illegal ops (2 cycles minimum).
// All outputs are registered or decoded from the state register only, so no
// input reaches an output combinationally.
// ---------------------------------------------------------------------------
module alu_issue_ctrl (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_e;

    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_e      state_q,            state_d;
    logic [3:0]  alu_control_q,      alu_control_d;
    logic [31:0] alu_inp1_q,         alu_inp1_d;
    logic [31:0] alu_inp2_q,         alu_inp2_d;
    br_kind_e    br_kind_q,          br_kind_d;
    logic [31:0] rsp_result_q,       rsp_result_d;
    logic        rsp_branch_taken_q, rsp_branch_taken_d;
    logic        rsp_illegal_q,      rsp_illegal_d;
    logic [31:0] op_count_q,         op_count_d;

    // -----------------------------------------------------------------------
    // Instruction decode, only consumed while IDLE accepts a request
    // -----------------------------------------------------------------------
    logic        dec_legal;
    logic [3:0]  dec_alu_op;
    logic        dec_use_imm;
    br_kind_e    dec_br_kind;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block; any path that skips an assignment would infer a latch.
    always_comb begin
        dec_legal   = 1'b0;
        dec_alu_op  = ALU_ADD;
        dec_use_imm = 1'b0;
        dec_br_kind = BR_NONE;

        case (bus.opcode)
            OP_RTYPE: begin
                case ({bus.funct7, bus.funct3})
                    {F7_BASE, F3_ADD}: begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
                    {F7_ALT,  F3_ADD}: begin dec_legal = 1'b1; dec_alu_op = ALU_SUB; end
                    {F7_BASE, F3_AND}: begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
                    {F7_BASE, F3_OR }: begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
                    default: ;
                endcase
            end

            // funct7 carries immediate bits here and is deliberately ignored.
            OP_ITYPE: begin
                dec_use_imm = 1'b1;
                case (bus.funct3)
                    F3_ADD:  begin dec_legal = 1'b1; dec_alu_op = ALU_ADD; end
                    F3_AND:  begin dec_legal = 1'b1; dec_alu_op = ALU_AND; end
                    F3_OR:   begin dec_legal = 1'b1; dec_alu_op = ALU_OR;  end
                    default: ;
                endcase
            end

            // Address generation: funct3 only selects access width downstream.
            OP_LOAD, OP_STORE: begin
                dec_legal   = 1'b1;
                dec_alu_op  = ALU_ADD;
                dec_use_imm = 1'b1;
            end

            // Branches compare by subtraction; the ALU zero flag decides.
            OP_BRANCH: begin
                dec_alu_op = ALU_SUB;
                case (bus.funct3)
                    F3_BEQ:  begin dec_legal = 1'b1; dec_br_kind = BR_EQ; end
                    F3_BNE:  begin dec_legal = 1'b1; dec_br_kind = BR_NE; end
                    default: ;
                endcase
            end

            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        state_d            = state_q;
        alu_control_d      = alu_control_q;
        alu_inp1_d         = alu_inp1_q;
        alu_inp2_d         = alu_inp2_q;
        br_kind_d          = br_kind_q;
        rsp_result_d       = rsp_result_q;
        rsp_branch_taken_d = rsp_branch_taken_q;
        rsp_illegal_d      = rsp_illegal_q;
        op_count_d         = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (dec_legal) begin
                        state_d       = ST_EXEC;
                        alu_control_d = dec_alu_op;
                        alu_inp1_d    = bus.rs1_data;
                        alu_inp2_d    = dec_use_imm ? bus.imm : bus.rs2_data;
                        br_kind_d     = dec_br_kind;
                    end else begin
                        // Skip the ALU cycle; the ALU inputs keep whatever
                        // the last legal op left there.
                        state_d            = ST_RESP;
                        rsp_result_d       = '0;
                        rsp_branch_taken_d = 1'b0;
                        rsp_illegal_d      = 1'b1;
                    end
                end
            end

            // The ALU has had a full cycle on the registered operands.
            ST_EXEC: begin
                state_d       = ST_RESP;
                rsp_result_d  = bus.alu_result;
                rsp_illegal_d = 1'b0;
                case (br_kind_q)
                    BR_EQ:   rsp_branch_taken_d = bus.alu_zeroflag;
                    BR_NE:   rsp_branch_taken_d = ~bus.alu_zeroflag;
                    default: rsp_branch_taken_d = 1'b0;
                endcase
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d    = ST_IDLE;
                    op_count_d = op_count_q + 32'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= ST_IDLE;
            alu_control_q      <= 4'b0000;
            alu_inp1_q         <= '0;
            alu_inp2_q         <= '0;
            br_kind_q          <= BR_NONE;
            rsp_result_q       <= '0;
            rsp_branch_taken_q <= 1'b0;
            rsp_illegal_q      <= 1'b0;
            op_count_q         <= '0;
        end else begin
            state_q            <= state_d;
            alu_control_q      <= alu_control_d;
            alu_inp1_q         <= alu_inp1_d;
            alu_inp2_q         <= alu_inp2_d;
            br_kind_q          <= br_kind_d;
            rsp_result_q       <= rsp_result_d;
            rsp_branch_taken_q <= rsp_branch_taken_d;
            rsp_illegal_q      <= rsp_illegal_d;
            op_count_q         <= op_count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: handshakes decode the state register, the rest are flops
    // -----------------------------------------------------------------------
    assign bus.req_ready        = (state_q == ST_IDLE);
    assign bus.rsp_valid        = (state_q == ST_RESP);
    assign bus.alu_control      = alu_control_q;
    assign bus.alu_inp1         = alu_inp1_q;
    assign bus.alu_inp2         = alu_inp2_q;
    assign bus.rsp_result       = rsp_result_q;
    assign bus.rsp_branch_taken = rsp_branch_taken_q;
    assign bus.rsp_illegal      = rsp_illegal_q;
    assign bus.op_count         = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed vectors for alu_issue_ctrl with a scoreboard: each issued request
// pushes its hand-computed response into a queue, and a monitor on the
// falling edge pops and compares on every response handshake. Inputs are
// driven 1 ns after the rising edge; outputs are sampled on the falling edge
// or 1 ns after the rising edge. A simple ALU model closes the loop.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [3:0] C_AND = 4'b0011;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0100;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        taken;
        logic        ill;
        logic [3:0]  ctrl;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus_if ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // ALU model
    logic [31:0] alu_model;
    always_comb begin
        alu_model = 32'h0;
        case (bus_if.alu_control)
            C_AND:   alu_model = bus_if.alu_inp1 & bus_if.alu_inp2;
            C_OR:    alu_model = bus_if.alu_inp1 | bus_if.alu_inp2;
            C_ADD:   alu_model = bus_if.alu_inp1 + bus_if.alu_inp2;
            C_SUB:   alu_model = bus_if.alu_inp1 - bus_if.alu_inp2;
            default: alu_model = 32'h0;
        endcase
    end
    assign bus_if.alu_result   = alu_model;
    assign bus_if.alu_zeroflag = (alu_model == 32'h0);

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] tb_count = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus_if.rsp_valid === 1'b1 && bus_if.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got result 0x%08h with no expected entry",
                         bus_if.rsp_result);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_result"},  bus_if.rsp_result,       mon_e.res);
                check({mon_e.name, "_taken"},   32'(bus_if.rsp_branch_taken), 32'(mon_e.taken));
                check({mon_e.name, "_illegal"}, 32'(bus_if.rsp_illegal), 32'(mon_e.ill));
                check({mon_e.name, "_alu_ctl"}, 32'(bus_if.alu_control), 32'(mon_e.ctrl));
                check({mon_e.name, "_alu_in1"}, bus_if.alu_inp1,         mon_e.in1);
                check({mon_e.name, "_alu_in2"}, bus_if.alu_inp2,         mon_e.in2);
                check({mon_e.name, "_opcount"}, bus_if.op_count,         mon_e.count);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (bus_if.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus_if.req_ready !== 1'b1) timeout({name, "_req_ready"});
    endtask

    // Issue one request, push its expected response, check latency.
    // Returns 1 ns after edge N+1 for legal ops, after edge N for illegal.
    task automatic send(input string name, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] res, input logic taken,
                        input logic ill, input logic [3:0] ctrl, input logic [31:0] in1,
                        input logic [31:0] in2);
        exp_t e;
        wait_ready(name);
        e.name = name; e.res = res; e.taken = taken; e.ill = ill;
        e.ctrl = ctrl; e.in1 = in1; e.in2 = in2; e.count = tb_count;
        exp_q.push_back(e);
        tb_count++;
        bus_if.req_valid = 1'b1;
        bus_if.opcode    = op;
        bus_if.funct3    = f3;
        bus_if.funct7    = f7;
        bus_if.rs1_data  = rs1;
        bus_if.rs2_data  = rs2;
        bus_if.imm       = imm;
        @(posedge clk); #1;               // edge N: accepted
        bus_if.req_valid = 1'b0;
        if (ill) begin
            check({name, "_valid_n"}, 32'(bus_if.rsp_valid), 32'h1);
        end else begin
            check({name, "_valid_n"}, 32'(bus_if.rsp_valid), 32'h0);
            @(posedge clk); #1;           // edge N+1
            check({name, "_valid_n1"}, 32'(bus_if.rsp_valid), 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.opcode    = '0;
        bus_if.funct3    = '0;
        bus_if.funct7    = '0;
        bus_if.rs1_data  = '0;
        bus_if.rs2_data  = '0;
        bus_if.imm       = '0;
        bus_if.rsp_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_req_ready", 32'(bus_if.req_ready),   32'h1);
        check("rst_rsp_valid", 32'(bus_if.rsp_valid),   32'h0);
        check("rst_alu_ctl",   32'(bus_if.alu_control), 32'h0);
        check("rst_alu_in1",   bus_if.alu_inp1,         32'h0);
        check("rst_alu_in2",   bus_if.alu_inp2,         32'h0);
        check("rst_result",    bus_if.rsp_result,       32'h0);
        check("rst_illegal",   32'(bus_if.rsp_illegal), 32'h0);
        check("rst_opcount",   bus_if.op_count,         32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        //    name        op     f3      f7          rs1           rs2           imm           res           tk ill ctrl   in1           in2
        send("ill_first", OP_R,  3'b001, 7'h00, 32'h1,        32'h2,        32'h0,        32'h0,        0, 1, 4'h0,  32'h0,        32'h0);
        send("add",       OP_R,  3'b000, 7'h00, 32'd5,        32'd7,        32'h0,        32'd12,       0, 0, C_ADD, 32'd5,        32'd7);
        send("sub",       OP_R,  3'b000, 7'h20, 32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 0, 0, C_SUB, 32'd3,        32'd5);
        send("beq_eq",    OP_BR, 3'b000, 7'h00, 32'h1234,     32'h1234,     32'h0,        32'h0,        1, 0, C_SUB, 32'h1234,     32'h1234);
        send("bne_eq",    OP_BR, 3'b001, 7'h00, 32'h1234,     32'h1234,     32'h0,        32'h0,        0, 0, C_SUB, 32'h1234,     32'h1234);
        send("bne_ne",    OP_BR, 3'b001, 7'h00, 32'd10,       32'd3,        32'h0,        32'd7,        1, 0, C_SUB, 32'd10,       32'd3);
        send("beq_ne",    OP_BR, 3'b000, 7'h00, 32'd10,       32'd3,        32'h0,        32'd7,        0, 0, C_SUB, 32'd10,       32'd3);
        send("andi",      OP_I,  3'b111, 7'h7F, 32'hF0F0,     32'hDEAD,     32'h0FF0,     32'h00F0,     0, 0, C_AND, 32'hF0F0,     32'h0FF0);
        send("ori",       OP_I,  3'b110, 7'h00, 32'hF000,     32'h0,        32'h000F,     32'hF00F,     0, 0, C_OR,  32'hF000,     32'h000F);
        send("load",      OP_LD, 3'b010, 7'h00, 32'h100,      32'h55,       32'hFFFFFFFC, 32'hFC,       0, 0, C_ADD, 32'h100,      32'hFFFFFFFC);
        send("store",     OP_ST, 3'b010, 7'h00, 32'h2000,     32'h77,       32'h8,        32'h2008,     0, 0, C_ADD, 32'h2000,     32'h8);
        send("and_r",     OP_R,  3'b111, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,        32'h0F000F00, 0, 0, C_AND, 32'hFF00FF00, 32'h0FF00FF0);
        send("or_r",      OP_R,  3'b110, 7'h00, 32'h1,        32'h80000000, 32'h0,        32'h80000001, 0, 0, C_OR,  32'h1,        32'h80000000);
        send("addi_wrap", OP_I,  3'b000, 7'h00, 32'hFFFFFFFF, 32'h0,        32'h1,        32'h0,        0, 0, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_r_f3",  OP_R,  3'b001, 7'h00, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_r_f7",  OP_R,  3'b000, 7'h01, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_and7",  OP_R,  3'b111, 7'h20, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_blt",   OP_BR, 3'b100, 7'h00, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_op",    7'h7F, 3'b000, 7'h00, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);
        send("ill_i_f3",  OP_I,  3'b001, 7'h00, 32'h9,        32'h9,        32'h0,        32'h0,        0, 1, C_ADD, 32'hFFFFFFFF, 32'h1);

        // Backpressure: hold RESP for 5 cycles while a new request is offered.
        wait_ready("bp_pre");
        bus_if.rsp_ready = 1'b0;
        send("bp_add", OP_R, 3'b000, 7'h00, 32'd100, 32'd23, 32'h0, 32'd123, 0, 0, C_ADD, 32'd100, 32'd23);
        bus_if.req_valid = 1'b1;
        bus_if.opcode    = OP_R;
        bus_if.funct3    = 3'b000;
        bus_if.funct7    = 7'h20;
        bus_if.rs1_data  = 32'd1;
        bus_if.rs2_data  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(bus_if.rsp_valid),   32'h1);
            check("bp_req_ready", 32'(bus_if.req_ready),   32'h0);
            check("bp_result",    bus_if.rsp_result,       32'd123);
            check("bp_illegal",   32'(bus_if.rsp_illegal), 32'h0);
            check("bp_alu_ctl",   32'(bus_if.alu_control), 32'(C_ADD));
            check("bp_opcount",   bus_if.op_count,         tb_count - 32'd1);
        end
        bus_if.req_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_opcount_after", bus_if.op_count,       tb_count);
        check("bp_valid_after",   32'(bus_if.rsp_valid), 32'h0);
        check("bp_ready_after",   32'(bus_if.req_ready), 32'h1);
        @(posedge clk); #1;
        check("bp_no_ghost", 32'(bus_if.rsp_valid), 32'h0);

        // Reset in the middle of EXEC: in-flight op is discarded.
        wait_ready("rst_pre");
        bus_if.req_valid = 1'b1;
        bus_if.opcode    = OP_R;
        bus_if.funct3    = 3'b000;
        bus_if.funct7    = 7'h00;
        bus_if.rs1_data  = 32'd40;
        bus_if.rs2_data  = 32'd2;
        @(posedge clk); #1;
        bus_if.req_valid = 1'b0;
        check("mid_exec_valid", 32'(bus_if.rsp_valid), 32'h0);
        check("mid_exec_ctl",   32'(bus_if.alu_control), 32'(C_ADD));
        reset = 1'b1;
        #1;
        check("mr_req_ready", 32'(bus_if.req_ready),        32'h1);
        check("mr_rsp_valid", 32'(bus_if.rsp_valid),        32'h0);
        check("mr_alu_ctl",   32'(bus_if.alu_control),      32'h0);
        check("mr_alu_in1",   bus_if.alu_inp1,              32'h0);
        check("mr_alu_in2",   bus_if.alu_inp2,              32'h0);
        check("mr_result",    bus_if.rsp_result,            32'h0);
        check("mr_taken",     32'(bus_if.rsp_branch_taken), 32'h0);
        check("mr_illegal",   32'(bus_if.rsp_illegal),      32'h0);
        check("mr_opcount",   bus_if.op_count,              32'h0);
        @(posedge clk); #1;
        reset    = 1'b0;
        tb_count = 32'h0;
        @(posedge clk); #1;
        send("post_rst_add", OP_R, 3'b000, 7'h00, 32'd5, 32'd7, 32'h0, 32'd12, 0, 0, C_ADD, 32'd5, 32'd7);

        // Drain the scoreboard.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) timeout("drain_scoreboard");
        @(posedge clk); #1;
        check("final_opcount", bus_if.op_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
